// File: rtl/div_top.sv
// Sequential unsigned Q5.5 divider: restoring division of {A, 5'b0} by B,
// one quotient bit per clock, with overflow saturation and divide-by-zero flag.
module div_top #(
    parameter int DATA_W = 10,
    parameter int FRAC_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] Q,
    output logic              busy,
    output logic              valid,
    output logic              ov,
    output logic              dvz
);

    localparam int N     = DATA_W + FRAC_W;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [N-1:0]        dvd_q, dvd_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                ov_q, ov_d;
    logic                dvz_q, dvz_d;

    logic [DATA_W:0]     rem_sh;
    logic [DATA_W-1:0]   rem_sub;
    logic                ge;
    logic [N-1:0]        quo_nxt;

    // Returns {ov, Q}: any set bit above the Q5.5 range saturates to all ones.
    function automatic logic [DATA_W:0] sat_q(input logic [N-1:0] raw);
        if (|raw[N-1:DATA_W])
            return {1'b1, {DATA_W{1'b1}}};
        else
            return {1'b0, raw[DATA_W-1:0]};
    endfunction

    always_comb begin
        rem_sh  = {rem_q, dvd_q[N-1]};
        ge      = (rem_sh >= {1'b0, b_q});
        // The difference is below b_q whenever it is used, so DATA_W bits suffice.
        rem_sub = rem_sh[DATA_W-1:0] - b_q;
        quo_nxt = {dvd_q[N-2:0], ge};

        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        b_d     = b_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ov_d    = ov_q;
        dvz_d   = dvz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    valid_d = 1'b0;
                    ov_d    = 1'b0;
                    dvz_d   = 1'b0;
                    if (B == '0) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        dvz_d   = 1'b1;
                        q_d     = '0;
                    end else begin
                        state_d = RUN;
                        dvd_d   = {A, {FRAC_W{1'b0}}};
                        b_d     = B;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                dvd_d = quo_nxt;
                rem_d = ge ? rem_sub : rem_sh[DATA_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d     = DONE;
                    valid_d     = 1'b1;
                    {ov_d, q_d} = sat_q(quo_nxt);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ov_q    <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ov_q    <= ov_d;
            dvz_q   <= dvz_d;
        end
    end

    assign Q     = q_q;
    assign busy  = (state_q == RUN);
    assign valid = valid_q;
    assign ov    = ov_q;
    assign dvz   = dvz_q;

endmodule

// File: tb/tb_div_top.sv
// Self-checking bench for div_top: vector table plus scoreboard queue,
// with hand-written sequences for mid-run start, reset abort and back-to-back use.
module tb_div_top;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] q;
        logic       ov;
        logic       dvz;
    } vec_t;

    typedef struct {
        logic [9:0] q;
        logic       ov;
        logic       dvz;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] A;
    logic [9:0] B;
    logic [9:0] Q;
    logic       busy;
    logic       valid;
    logic       ov;
    logic       dvz;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[10];

    div_top dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .busy  (busy),
        .valid (valid),
        .ov    (ov),
        .dvz   (dvz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Independent reference: integer floor division with saturation.
    function automatic exp_t model(input logic [9:0] a, input logic [9:0] b);
        exp_t e;
        int   raw;
        e.q = '0; e.ov = 1'b0; e.dvz = 1'b0;
        if (b == 0) begin
            e.dvz = 1'b1;
        end else begin
            raw = (int'(a) * 32) / int'(b);
            if (raw > 1023) begin
                e.ov = 1'b1;
                e.q  = 10'h3FF;
            end else begin
                e.q = raw[9:0];
            end
        end
        return e;
    endfunction

    // Issue one division, push its expectation, then wait for and score the result.
    // mid >= 0 raises a stray start (with other operands) that many cycles into RUN.
    task automatic do_op(input logic [9:0] a, input logic [9:0] b,
                         input logic [9:0] eq, input logic eov, input logic edvz,
                         input int mid);
        exp_t e;
        int   cyc;
        e.q = eq; e.ov = eov; e.dvz = edvz;
        sb.push_back(e);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 10'($urandom);
        B = 10'($urandom);
        if (b == 0) begin
            chk("dvz_path_busy", busy, 0);
        end else begin
            chk("accept_valid_cleared", valid, 0);
            chk("accept_busy", busy, 1);
            chk("accept_flags_cleared", {ov, dvz}, 0);
            cyc = 0;
            while (!valid && cyc < 40) begin
                if (cyc == mid) begin
                    start = 1'b1; A = 10'd1; B = 10'd1;
                end
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
                if (!valid && !busy) begin
                    errors++;
                    $display("FAIL busy_during_run: got 0, expected 1 at cycle %0d", cyc);
                end
            end
            chk("latency", cyc, 15);
        end
        chk("done_valid", valid, 1);
        chk("done_busy", busy, 0);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb.pop_front();
            chk("result_Q", Q, e.q);
            chk("result_ov", ov, e.ov);
            chk("result_dvz", dvz, e.dvz);
        end
    endtask

    initial begin
        exp_t m;
        logic [9:0] hq;
        int   seen;

        vecs[0] = '{10'b0000100000, 10'b0001000000, 10'b0000010000, 1'b0, 1'b0}; // 1.0/2.0
        vecs[1] = '{10'b1010110110, 10'b0000001000, 10'h3FF,        1'b1, 1'b0}; // overflow
        vecs[2] = '{10'b1101010000, 10'd0,          10'd0,          1'b0, 1'b1}; // div by 0
        vecs[3] = '{10'd0,          10'd5,          10'd0,          1'b0, 1'b0}; // A=0
        vecs[4] = '{10'd1023,       10'd1023,       10'd32,         1'b0, 1'b0}; // 1.0
        vecs[5] = '{10'd1,          10'd1023,       10'd0,          1'b0, 1'b0}; // underflow
        vecs[6] = '{10'd31,         10'd1,          10'd992,        1'b0, 1'b0}; // just fits
        vecs[7] = '{10'd32,         10'd1,          10'h3FF,        1'b1, 1'b0}; // 1024 saturates
        vecs[8] = '{10'd1023,       10'd32,         10'd1023,       1'b0, 1'b0}; // max exact
        vecs[9] = '{10'd100,        10'd7,          10'd457,        1'b0, 1'b0}; // 3200/7

        rst = 1'b0; start = 1'b0; A = '0; B = '0;
        #1;
        chk("reset_outputs", {Q, busy, valid, ov, dvz}, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // First rising edge after release accepts this start.
        for (int i = 0; i < 10; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ov, vecs[i].dvz, -1);

        // Result holds in DONE without start.
        hq = Q;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_valid", valid, 1);
        chk("hold_Q", Q, hq);

        // 6.0 / 1.5 = 4.0 with a stray start mid-RUN.
        do_op(10'b0011000000, 10'b0000110000, 10'b0010000000, 1'b0, 1'b0, 5);

        // Reset during RUN cycle 7 aborts immediately.
        @(negedge clk);
        A = 10'd192; B = 10'd48; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_reset_outputs", {Q, busy, valid, ov, dvz}, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid || busy) seen++;
        end
        chk("no_valid_after_abort", seen, 0);
        do_op(10'd200, 10'd9, 10'd711, 1'b0, 1'b0, -1);

        // Back-to-back random operations, each started from DONE.
        for (int i = 0; i < 6; i++) begin
            logic [9:0] ra, rb;
            ra = 10'($urandom);
            rb = (i == 3) ? 10'd0 : 10'($urandom_range(1, 1023));
            m  = model(ra, rb);
            do_op(ra, rb, m.q, m.ov, m.dvz, -1);
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_top.md
DIV_TOP -- requirements
Module: div_top

Interface
REQ-001 The block SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have rst, input, 1 bit: reset, asynchronous and active-low (asserted when 0).
REQ-003 The block SHALL have start, input, 1 bit: request to begin a division, sampled on a rising clk edge.
REQ-004 The block SHALL have A, input, 10 bits: dividend, unsigned fixed-point Q5.5 (5 integer bits, 5 fraction bits).
REQ-005 The block SHALL have B, input, 10 bits: divisor, unsigned fixed-point Q5.5.
REQ-006 The block SHALL have Q, output, 10 bits: quotient, unsigned Q5.5.
REQ-007 The block SHALL have busy, output, 1 bit: a division is in progress.
REQ-008 The block SHALL have valid, output, 1 bit: Q, ov and dvz hold the result of the last accepted division.
REQ-009 The block SHALL have ov, output, 1 bit: the quotient overflowed the Q5.5 range.
REQ-010 The block SHALL have dvz, output, 1 bit: divide by zero (B was 0).

Function
REQ-011 The block SHALL accept start=1 only in states IDLE or DONE, and SHALL latch A and B internally on that edge.
REQ-012 The block SHALL ignore start while busy=1; latched operands SHALL NOT change mid-operation.
REQ-013 The block SHALL have a state machine with states IDLE, RUN and DONE, plus reset to IDLE.
REQ-014 The transitions SHALL be: IDLE/DONE + start with B!=0 -> RUN; IDLE/DONE + start with B==0 -> DONE; RUN after 15 iterations -> DONE; DONE without start -> DONE.
REQ-015 On acceptance, the block SHALL clear valid, ov and dvz in the same edge and set busy=1 (except for the B==0 path).
REQ-016 The block SHALL compute the mathematical result floor((A * 32) / B) using a 15-bit dividend {A, 5'b0} and unsigned restoring (or non-restoring) division.
REQ-017 The division SHALL produce one quotient bit per clock, MSB first, for 15 RUN cycles, using a partial remainder of at least 11 bits.
REQ-018 Latency: if start is accepted at edge T0, busy SHALL be 1 after T0 through T15, and busy=0 with valid=1 SHALL hold after edge T15 (15 cycles).
REQ-019 If the 15-bit raw quotient has any of its upper 5 bits set, the block SHALL set ov=1 and saturate Q to 10'h3FF; otherwise ov=0 and Q SHALL be the low 10 bits.
REQ-020 If B==0 at acceptance, after the next edge the block SHALL output dvz=1, valid=1, ov=0, Q=0, busy=0, with no RUN cycles.
REQ-021 Q, ov, dvz and valid SHALL hold in DONE until the next accepted start or reset.
REQ-022 A start in DONE SHALL begin a new division on that edge (back-to-back operation).
REQ-023 A=0 with B!=0 SHALL take the full latency and give Q=0, ov=0.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for a clock, force state=IDLE, Q=0, busy=0, valid=0, ov=0, dvz=0, and clear the internal registers.
REQ-025 Reset asserted mid-RUN SHALL abort the division; no valid SHALL follow after release until a new start.
REQ-026 After release of rst, the block SHALL accept start on the first rising edge.

Verification
REQ-027 A bench SHALL check: A=10'b0000100000 (1.0), B=10'b0001000000 (2.0), start pulse of 1 cycle -> after 15 cycles valid=1, Q=10'b0000010000 (0.5), ov=0, dvz=0, busy low.
REQ-028 A bench SHALL check: A=10'b1010110110 (21.6875), B=10'b0000001000 (0.25) -> valid=1, ov=1, Q=10'h3FF, dvz=0 after 15 cycles.
REQ-029 A bench SHALL check: A=10'b1101010000, B=0 -> valid=1, dvz=1, Q=0, ov=0 one cycle after start, with busy never asserted.
REQ-030 A bench SHALL check: A=10'b0011000000 (6.0), B=10'b0000110000 (1.5) -> Q=10'b0010000000 (4.0), ov=0; a second start mid-RUN is ignored and Q is unchanged.
REQ-031 A bench SHALL check: rst driven to 0 at RUN cycle 7 -> all outputs are 0 immediately; after release, a new division completes correctly.
REQ-032 A bench SHALL check: back-to-back start pulses in DONE -> each result matches floor(A*32/B) with saturation, and valid drops on each acceptance.
